// File: rtl/div8_pkg.sv
// Shared definitions for the sequential 8-bit divider: default operand
// width and the controller state encoding.
package div8_pkg;

   localparam int DIV_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : div8_pkg

// File: rtl/div8_seq_if.sv
// Request/result bundle for the sequential divider. The master issues
// operands and START; the slave (divider side) returns READY/VALID/results.
interface div8_seq_if
   import div8_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic             ready;
   logic             valid;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             div0;

   modport master (
      output start, i0, i1,
      input  ready, valid, q, r, div0
   );

   modport slave (
      input  start, i0, i1,
      output ready, valid, q, r, div0
   );
endinterface : div8_seq_if

// File: rtl/div8_seq_div_step.sv
// One restoring-division step: WIDTH+1-bit remainder minus zero-extended
// divisor, done as invert + add with carry-in 1. A missing carry-out means
// the subtraction borrowed (remainder < divisor). Purely combinational.
module div_step
   import div8_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
)
(
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH:0]   diff_o,
   output logic             borrow_o
);

   logic [WIDTH+1:0] sum;

   assign sum      = {1'b0, rem_i} + {1'b0, ~{1'b0, dvs_i}} + {{(WIDTH+1){1'b0}}, 1'b1};
   assign diff_o   = sum[WIDTH:0];
   assign borrow_o = ~sum[WIDTH+1];

endmodule : div_step

// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB
// first. IDLE waits for START, RUN iterates WIDTH times, DONE presents a
// one-cycle VALID and may immediately accept the next operation. A zero
// divisor skips RUN and reports Q=all ones, R=dividend, DIV0=1.
module div8_seq
   import div8_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
)
(
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             START,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   output logic             READY,
   output logic             VALID,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             DIV0
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB,
   // so after WIDTH steps this register holds the quotient.
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             div0_q, div0_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic             unused_rem_msb;

   // A restored remainder is always below the divisor, so its top bit is
   // zero and drops out of the shift.
   assign shifted        = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
   assign unused_rem_msb = rem_q[WIDTH];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i    (shifted),
      .dvs_i    (dvs_q),
      .diff_o   (diff),
      .borrow_o (borrow)
   );

   // Next-state, datapath and result-register update logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      q_d     = q_q;
      r_d     = r_q;
      div0_d  = div0_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (START) begin
               dvd_d = I0;
               dvs_d = I1;
               rem_d = '0;
               cnt_d = '0;
               if (I1 == '0) begin
                  state_d = DONE;
                  q_d     = '1;
                  r_d     = I0;
                  div0_d  = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            rem_d = borrow ? shifted : diff;
            dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               q_d     = dvd_d;
               r_d     = rem_d[WIDTH-1:0];
               div0_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and data registers with asynchronous active-low clear.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         q_q     <= q_d;
         r_q     <= r_d;
         div0_q  <= div0_d;
      end
   end

   assign READY = (state_q != RUN);
   assign VALID = (state_q == DONE);
   assign Q     = q_q;
   assign R     = r_q;
   assign DIV0  = div0_q;

endmodule : div8_seq

// File: tb/tb_div8_seq.sv
// Directed plus randomized checks of div8_seq against plain-arithmetic
// expectations (a / d, a % d, zero-divisor rule).
module tb_div8_seq;
   import div8_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   logic [7:0] prev_q;
   logic [7:0] prev_r;
   logic       prev_div0;

   div8_seq_if #(.WIDTH(8)) bus ();

   div8_seq #(.WIDTH(8)) dut (
      .CLK         (clk),
      .ASYNCRESETN (rst_n),
      .START       (bus.start),
      .I0          (bus.i0),
      .I1          (bus.i1),
      .READY       (bus.ready),
      .VALID       (bus.valid),
      .Q           (bus.q),
      .R           (bus.r),
      .DIV0        (bus.div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one request for a cycle, then scramble the operand inputs.
   task automatic start_op(input logic [7:0] a, input logic [7:0] d);
      bus.start = 1'b1;
      bus.i0    = a;
      bus.i1    = d;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.i0    = 8'($urandom);
      bus.i1    = 8'($urandom);
   endtask

   // Wait for VALID, checking busy/hold behaviour each cycle, then the result.
   task automatic wait_valid(input logic [7:0] a, input logic [7:0] d,
                             input int first_cyc, input string tag);
      int         cyc;
      bit         seen;
      logic [7:0] eq;
      logic [7:0] er;
      logic       ediv0;
      cyc  = first_cyc;
      seen = 1'b0;
      while (!seen && cyc <= 20) begin
         if (bus.valid === 1'b1) begin
            seen = 1'b1;
         end else begin
            chk({tag, " ready_busy"}, 32'(bus.ready), 32'd0);
            chk({tag, " q_hold"}, 32'(bus.q), 32'(prev_q));
            chk({tag, " r_hold"}, 32'(bus.r), 32'(prev_r));
            chk({tag, " div0_hold"}, 32'(bus.div0), 32'(prev_div0));
            @(posedge clk); #1;
            cyc++;
         end
      end
      chk({tag, " latency"}, seen ? 32'(cyc) : 32'd999, (d == 8'd0) ? 32'd1 : 32'd9);
      if (d == 8'd0) begin
         eq = 8'hFF; er = a; ediv0 = 1'b1;
      end else begin
         eq = a / d; er = a % d; ediv0 = 1'b0;
      end
      chk({tag, " q"}, 32'(bus.q), 32'(eq));
      chk({tag, " r"}, 32'(bus.r), 32'(er));
      chk({tag, " div0"}, 32'(bus.div0), 32'(ediv0));
      chk({tag, " ready_done"}, 32'(bus.ready), 32'd1);
      $display("op %0d / %0d -> q=%0d r=%0d div0=%0d after %0d cycles",
               a, d, bus.q, bus.r, bus.div0, cyc);
      prev_q    = eq;
      prev_r    = er;
      prev_div0 = ediv0;
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rd;
      n_vec     = 0;
      n_err     = 0;
      prev_q    = 8'd0;
      prev_r    = 8'd0;
      prev_div0 = 1'b0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.i0    = 8'd0;
      bus.i1    = 8'd0;

      // Reset state.
      #1;
      chk("rst ready", 32'(bus.ready), 32'd1);
      chk("rst valid", 32'(bus.valid), 32'd0);
      chk("rst q", 32'(bus.q), 32'd0);
      chk("rst r", 32'(bus.r), 32'd0);
      chk("rst div0", 32'(bus.div0), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed divisions.
      start_op(8'd200, 8'd7);   wait_valid(8'd200, 8'd7, 1, "d200_7");
      @(posedge clk); #1;
      chk("d200_7 valid_pulse", 32'(bus.valid), 32'd0);
      start_op(8'd255, 8'd1);   wait_valid(8'd255, 8'd1, 1, "d255_1");
      @(posedge clk); #1;
      start_op(8'd5, 8'd9);     wait_valid(8'd5, 8'd9, 1, "d5_9");
      @(posedge clk); #1;
      start_op(8'd0, 8'd3);     wait_valid(8'd0, 8'd3, 1, "d0_3");
      @(posedge clk); #1;

      // Zero divisor, then a normal division clears DIV0.
      start_op(8'd77, 8'd0);    wait_valid(8'd77, 8'd0, 1, "d77_0");
      @(posedge clk); #1;
      chk("d77_0 valid_pulse", 32'(bus.valid), 32'd0);
      start_op(8'd12, 8'd5);    wait_valid(8'd12, 8'd5, 1, "d12_5");
      @(posedge clk); #1;

      // START while busy is ignored.
      start_op(8'd100, 8'd10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.i0 = 8'd9; bus.i1 = 8'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_valid(8'd100, 8'd10, 4, "d100_10_ign");
      @(posedge clk); #1;
      chk("ign no_rerun", 32'(bus.valid), 32'd0);
      chk("ign idle_ready", 32'(bus.ready), 32'd1);

      // Reset during RUN aborts; first START after release is accepted.
      start_op(8'd90, 8'd4);
      repeat (3) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      chk("abort ready", 32'(bus.ready), 32'd1);
      chk("abort valid", 32'(bus.valid), 32'd0);
      chk("abort q", 32'(bus.q), 32'd0);
      chk("abort r", 32'(bus.r), 32'd0);
      prev_q = 8'd0; prev_r = 8'd0; prev_div0 = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      bus.start = 1'b1; bus.i0 = 8'd143; bus.i1 = 8'd11;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.i0 = 8'($urandom); bus.i1 = 8'($urandom);
      wait_valid(8'd143, 8'd11, 1, "post_rst");
      @(posedge clk); #1;

      // Back-to-back accept in the VALID cycle.
      start_op(8'd30, 8'd4);    wait_valid(8'd30, 8'd4, 1, "b2b_first");
      start_op(8'd50, 8'd6);    wait_valid(8'd50, 8'd6, 1, "b2b_second");
      start_op(8'd66, 8'd0);    wait_valid(8'd66, 8'd0, 1, "b2b_div0");
      @(posedge clk); #1;

      // Randomized operations with occasional zero divisors and idle gaps.
      for (int k = 0; k < 40; k++) begin
         ra = 8'($urandom);
         rd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         start_op(ra, rd);
         wait_valid(ra, rd, 1, $sformatf("rand%0d", k));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_div8_seq
